// File: rtl/mixer_pkg.sv
// Shared constants, state encoding and accumulator sizing for the voice mixer.
package mixer_pkg;

  localparam int PROD_W   = 24;
  localparam int SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  // One extra bit beyond clog2 keeps the sum of NVOICES full-scale products in range.
  function automatic int acc_width(input int nvoices);
    return PROD_W + $clog2(nvoices) + 1;
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Frame handshake between the mixer (master) and the i2s serializer (slave).
interface voice_mixer_if;

  logic        i2s_ready;
  logic [31:0] sample_out;
  logic        sample_valid;

  modport master (
    input  i2s_ready,
    output sample_out,
    output sample_valid
  );

  modport slave (
    output i2s_ready,
    input  sample_out,
    input  sample_valid
  );

endinterface

// File: rtl/mixer_sat.sv
// Arithmetic right shift (floor) of a wide accumulator followed by 16-bit saturation.
module mixer_sat
  import mixer_pkg::*;
#(
  parameter int ACC_W = 28
) (
  input  logic signed [ACC_W-1:0]    i_acc,
  input  logic        [3:0]          i_shift,
  output logic signed [SAMPLE_W-1:0] o_sat
);

  localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] W_MIN = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] w_shifted;

  assign w_shifted = i_acc >>> i_shift;

  always_comb begin
    o_sat = w_shifted[SAMPLE_W-1:0];
    if (w_shifted > W_MAX) begin
      o_sat = SAT_MAX;
    end else if (w_shifted < W_MIN) begin
      o_sat = SAT_MIN;
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Snapshots NVOICES voices on i2s_ready, accumulates gain*voice one voice per clock
// into L/R, then shifts, saturates and presents a {L,R} frame.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NVOICES = 6,
  parameter int GAIN_W  = 8
) (
  input  logic                          clk24,
  input  logic                          rst_n,
  voice_mixer_if.master                 bus,
  input  logic [NVOICES*SAMPLE_W-1:0]   voices,
  input  logic [NVOICES*GAIN_W-1:0]     gains,
  input  logic [NVOICES-1:0]            pan_l,
  input  logic [NVOICES-1:0]            pan_r,
  input  logic [3:0]                    master_shift,
  input  logic                          clear_overrun,
  output logic                          busy,
  output logic                          overrun
);

  localparam int ACC_W = acc_width(NVOICES);
  localparam int IDX_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam int MUL_W = SAMPLE_W + GAIN_W + 1;

  logic [1:0]                       r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [NVOICES*SAMPLE_W-1:0]      r_voices;
  logic [NVOICES*GAIN_W-1:0]        r_gains;
  logic [NVOICES-1:0]               r_panL;
  logic [NVOICES-1:0]               r_panR;
  logic [3:0]                       r_shift;
  logic signed [ACC_W-1:0]          r_accL;
  logic signed [ACC_W-1:0]          r_accR;
  logic [2*SAMPLE_W-1:0]            r_sampleOut;
  logic                             r_sampleValid;
  logic                             r_overrun;

  logic signed [SAMPLE_W-1:0]       w_voice;
  logic [GAIN_W-1:0]                w_gain;
  logic signed [GAIN_W:0]           w_gainExt;
  logic signed [MUL_W-1:0]          w_prod;
  logic signed [ACC_W-1:0]          w_prodExt;
  logic                             w_lastVoice;
  logic signed [SAMPLE_W-1:0]       w_satL;
  logic signed [SAMPLE_W-1:0]       w_satR;

  // Gain is unsigned, so a zero MSB makes it a non-negative signed multiplicand.
  assign w_voice     = r_voices[r_idx*SAMPLE_W +: SAMPLE_W];
  assign w_gain      = r_gains[r_idx*GAIN_W +: GAIN_W];
  assign w_gainExt   = {1'b0, w_gain};
  assign w_prod      = w_voice * w_gainExt;
  assign w_prodExt   = ACC_W'(w_prod);
  assign w_lastVoice = (r_idx == IDX_W'(NVOICES - 1));

  assign busy             = (r_state != ST_IDLE);
  assign overrun          = r_overrun;
  assign bus.sample_out   = r_sampleOut;
  assign bus.sample_valid = r_sampleValid;

  mixer_sat #(.ACC_W(ACC_W)) u_satL (
    .i_acc   (r_accL),
    .i_shift (r_shift),
    .o_sat   (w_satL)
  );

  mixer_sat #(.ACC_W(ACC_W)) u_satR (
    .i_acc   (r_accR),
    .i_shift (r_shift),
    .o_sat   (w_satR)
  );

  // A new mix only starts from IDLE; a pulse in ACCUM or OUT just flags overrun.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_voices      <= '0;
      r_gains       <= '0;
      r_panL        <= '0;
      r_panR        <= '0;
      r_shift       <= '0;
      r_accL        <= '0;
      r_accR        <= '0;
      r_sampleOut   <= '0;
      r_sampleValid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_sampleValid <= 1'b0;

      if (bus.i2s_ready && busy) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.i2s_ready) begin
            r_voices <= voices;
            r_gains  <= gains;
            r_panL   <= pan_l;
            r_panR   <= pan_r;
            r_shift  <= master_shift;
            r_accL   <= '0;
            r_accR   <= '0;
            r_idx    <= '0;
            r_state  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (r_panL[r_idx]) begin
            r_accL <= r_accL + w_prodExt;
          end
          if (r_panR[r_idx]) begin
            r_accR <= r_accR + w_prodExt;
          end
          if (w_lastVoice) begin
            r_state <= ST_OUT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_OUT: begin
          r_sampleOut   <= {w_satL, w_satR};
          r_sampleValid <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboarded bench for voice_mixer: directed frames, overrun/reset cases and
// random frames checked against an integer-arithmetic mixing model.
module tb_voice_mixer;

  localparam int NV  = 6;
  localparam int GW  = 8;
  localparam int LAT = NV + 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic              clk24 = 1'b0;
  logic              rst_n = 1'b0;
  logic [NV*16-1:0]  voicesBus = '0;
  logic [NV*GW-1:0]  gainsBus = '0;
  logic [NV-1:0]     panLBus = '0;
  logic [NV-1:0]     panRBus = '0;
  logic [3:0]        shiftBus = '0;
  logic              clearOverrun = 1'b0;
  logic              busy;
  logic              overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sbQ[$];

  int fv[NV];
  int fg[NV];
  bit fl[NV];
  bit fr[NV];
  int fsh;

  voice_mixer_if mixIf();

  voice_mixer #(.NVOICES(NV), .GAIN_W(GW)) dut (
    .clk24         (clk24),
    .rst_n         (rst_n),
    .bus           (mixIf),
    .voices        (voicesBus),
    .gains         (gainsBus),
    .pan_l         (panLBus),
    .pan_r         (panRBus),
    .master_shift  (shiftBus),
    .clear_overrun (clearOverrun),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk24 = ~clk24;
  always @(posedge clk24) cyc <= cyc + 1;

  function automatic logic [15:0] satRef(input longint a);
    longint t;
    if (a > 32767) return 16'h7FFF;
    if (a < -32768) return 16'h8000;
    t = a;
    return t[15:0];
  endfunction

  // Mix = floor((sum of voice*gain over panned voices) / 2^shift), clamped to int16.
  function automatic logic [31:0] modelFrame();
    longint accL = 0;
    longint accR = 0;
    for (int k = 0; k < NV; k++) begin
      if (fl[k]) accL += longint'(fv[k]) * longint'(fg[k]);
      if (fr[k]) accR += longint'(fv[k]) * longint'(fg[k]);
    end
    return {satRef(accL >>> fsh), satRef(accR >>> fsh)};
  endfunction

  task automatic clearFrame();
    for (int k = 0; k < NV; k++) begin
      fv[k] = 0; fg[k] = 0; fl[k] = 1'b0; fr[k] = 1'b0;
    end
    fsh = 7;
  endtask

  task automatic applyInputs();
    for (int k = 0; k < NV; k++) begin
      voicesBus[k*16 +: 16] = fv[k][15:0];
      gainsBus[k*GW +: GW]  = fg[k][GW-1:0];
      panLBus[k]            = fl[k];
      panRBus[k]            = fr[k];
    end
    shiftBus = fsh[3:0];
  endtask

  task automatic scrambleInputs();
    for (int k = 0; k < NV; k++) voicesBus[k*16 +: 16] = 16'($urandom);
    gainsBus = NV*GW'($urandom);
    panLBus  = NV'($urandom);
    panRBus  = NV'($urandom);
    shiftBus = 4'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic applyStimulus(input bit push, input logic [31:0] expData);
    applyInputs();
    mixIf.i2s_ready = 1'b1;
    if (push) sbQ.push_back('{data: expData, cyc: cyc + LAT});
    @(posedge clk24); #1;
    mixIf.i2s_ready = 1'b0;
    scrambleInputs();
  endtask

  task automatic pulseReady(input logic withClear);
    mixIf.i2s_ready = 1'b1;
    clearOverrun    = withClear;
    @(posedge clk24); #1;
    mixIf.i2s_ready = 1'b0;
    clearOverrun    = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sbQ.size() != 0 && n < 40) begin
      @(posedge clk24); #1;
      n++;
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d pending frames expected 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk24); #1;
    end
  endtask

  // Monitor: every sample_valid must match the oldest expected frame and its due cycle.
  always @(negedge clk24) begin
    if (rst_n && mixIf.sample_valid) begin
      exp_t e;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got sample 0x%08h at cycle %0d expected none", mixIf.sample_out, cyc);
      end else begin
        e = sbQ.pop_front();
        checks++;
        if (mixIf.sample_out !== e.data) begin
          errors++;
          $display("[TB] FAIL frame_data: got 0x%08h expected 0x%08h", mixIf.sample_out, e.data);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL frame_latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mixIf.i2s_ready = 1'b0;
    clearFrame();
    idle(3);
    checkOutput("reset_sample_out", mixIf.sample_out, 32'h0);
    checkOutput("reset_valid", {31'h0, mixIf.sample_valid}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    clearFrame(); fv[0] = 16384; fg[0] = 128; fl[0] = 1; fr[0] = 1;
    applyStimulus(1, 32'h4000_4000);
    checkOutput("busy_after_ready", {31'h0, busy}, 32'h1);
    waitDrain("unity");

    clearFrame(); fv[1] = 1000; fg[1] = 128; fl[1] = 1;
    applyStimulus(1, 32'h03E8_0000);
    waitDrain("pan");

    clearFrame();
    for (int k = 0; k < NV; k++) begin fv[k] = 32767; fg[k] = 255; fl[k] = 1; fr[k] = 1; end
    applyStimulus(1, 32'h7FFF_7FFF);
    waitDrain("sat_pos");

    clearFrame();
    for (int k = 0; k < NV; k++) begin fv[k] = -32768; fg[k] = 255; fl[k] = 1; fr[k] = 1; end
    applyStimulus(1, 32'h8000_8000);
    waitDrain("sat_neg");

    clearFrame(); fv[0] = -1; fg[0] = 1; fl[0] = 1; fr[0] = 1;
    applyStimulus(1, 32'hFFFF_FFFF);
    waitDrain("floor_neg");

    clearFrame(); fv[0] = 1; fg[0] = 1; fl[0] = 1; fr[0] = 1;
    applyStimulus(1, 32'h0000_0000);
    waitDrain("floor_pos");

    // Second pulse three cycles into a mix: ignored, flagged as overrun.
    checkOutput("overrun_idle", {31'h0, overrun}, 32'h0);
    clearFrame(); fv[0] = 16384; fg[0] = 128; fl[0] = 1; fr[0] = 1;
    applyStimulus(1, 32'h4000_4000);
    idle(2);
    clearFrame(); fv[2] = 5000; fg[2] = 200; fl[2] = 1; fr[2] = 1;
    applyInputs();
    pulseReady(1'b0);
    waitDrain("overrun_frame");
    idle(12);
    checkOutput("overrun_set", {31'h0, overrun}, 32'h1);
    clearOverrun = 1'b1;
    idle(1);
    clearOverrun = 1'b0;
    checkOutput("overrun_clear", {31'h0, overrun}, 32'h0);

    // Pulse during OUT together with clear_overrun: set must win, no restart.
    clearFrame(); fv[3] = 16384; fg[3] = 128; fl[3] = 1; fr[3] = 1;
    applyStimulus(1, 32'h4000_4000);
    idle(LAT - 2);
    checkOutput("busy_in_out", {31'h0, busy}, 32'h1);
    pulseReady(1'b1);
    checkOutput("overrun_set_wins", {31'h0, overrun}, 32'h1);
    waitDrain("out_overrun");
    idle(12);

    // Reset mid-mix discards the partial result and clears everything.
    clearFrame(); fv[0] = 1234; fg[0] = 128; fl[0] = 1; fr[0] = 1;
    applyStimulus(0, 32'h0);
    idle(3);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_sample_out", mixIf.sample_out, 32'h0);
    checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
    checkOutput("midreset_overrun", {31'h0, overrun}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(12);
    clearFrame(); fv[0] = 1234; fg[0] = 128; fl[0] = 1; fr[0] = 1;
    applyStimulus(1, 32'h04D2_04D2);
    waitDrain("after_reset");

    for (int t = 0; t < 40; t++) begin
      clearFrame();
      for (int k = 0; k < NV; k++) begin
        case ($urandom_range(0, 3))
          0:       fv[k] = 32767;
          1:       fv[k] = -32768;
          default: fv[k] = int'(shortint'($urandom));
        endcase
        fg[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
        fl[k] = 1'($urandom);
        fr[k] = 1'($urandom);
      end
      fsh = int'($urandom_range(0, 15));
      applyStimulus(1, modelFrame());
      waitDrain("random");
      idle(int'($urandom_range(0, 3)));
    end

    idle(12);
    checkOutput("final_overrun", {31'h0, overrun}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
